// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EXE/MEM destination tracking, operand forwarding selects and load-use stall for the ID stage
module hazard_scoreboard #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_flush,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             depen,
  output logic             wpcir,
  output logic             exe_load,
  output logic [CNT_W-1:0] stall_cnt
);
  logic            e_wreg, e_m2reg, m_wreg, m_m2reg;
  logic [RA_W-1:0] e_rd, m_rd;
  logic            e_ok, m_ok, ehit_rs, ehit_rt, mhit_rs, mhit_rt, issue;
  always_comb begin
    e_ok     = e_wreg & (e_rd != '0);
    m_ok     = m_wreg & (m_rd != '0);
    ehit_rs  = id_valid & id_use_rs & e_ok & (e_rd == id_rs);
    ehit_rt  = id_valid & id_use_rt & e_ok & (e_rd == id_rt);
    mhit_rs  = id_valid & id_use_rs & m_ok & (m_rd == id_rs);
    mhit_rt  = id_valid & id_use_rt & m_ok & (m_rd == id_rt);
    exe_load = e_ok & e_m2reg;
    depen    = exe_load & (ehit_rs | ehit_rt);
    wpcir    = ~depen;
    issue    = id_valid & ~id_flush & ~depen;
    fwda     = (ehit_rs & ~e_m2reg) ? 2'b01 : mhit_rs ? (m_m2reg ? 2'b11 : 2'b10) : 2'b00;
    fwdb     = (ehit_rt & ~e_m2reg) ? 2'b01 : mhit_rt ? (m_m2reg ? 2'b11 : 2'b10) : 2'b00;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      e_wreg    <= 1'b0;
      e_m2reg   <= 1'b0;
      e_rd      <= '0;
      m_wreg    <= 1'b0;
      m_m2reg   <= 1'b0;
      m_rd      <= '0;
      stall_cnt <= '0;
    end else begin
      m_wreg    <= e_wreg;
      m_m2reg   <= e_m2reg;
      m_rd      <= e_rd;
      e_wreg    <= issue & id_wreg;
      e_m2reg   <= issue & id_m2reg;
      e_rd      <= issue ? id_rd : '0;
      stall_cnt <= (depen && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
    end
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Data-hazard control unit for the five-stage pipelined CPU. It sits beside the ID stage and feeds the ID/EXE pipeline register and the PC/IF-ID write enables.
- It tracks the destination register of every instruction in EXE and MEM, and produces the per-operand forwarding selects (A_DEPEN/B_DEPEN in the CPU top), the load-use stall (DEPEN) and the exe_load flag.
- It keeps a saturating stall counter for bench and performance visibility.

Parameters:
- RA_W, 5, register-address width.
- CNT_W, 16, width of the stall counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs  in  RA_W  source register A of the ID instruction.
- id_rt  in  RA_W  source register B of the ID instruction.
- id_use_rs  in  1  the ID instruction reads rs.
- id_use_rt  in  1  the ID instruction reads rt.
- id_wreg  in  1  the ID instruction writes the register file.
- id_m2reg  in  1  the ID instruction is a load (result comes from memory).
- id_rd  in  RA_W  destination register of the ID instruction.
- id_flush  in  1  kill the ID instruction (branch taken); insert a bubble.
- fwda  out  2  operand-A select: 00 regfile, 01 EXE ALU, 10 MEM ALU, 11 MEM load data.
- fwdb  out  2  operand-B select, same encoding as fwda.
- depen  out  1  load-use stall request.
- wpcir  out  1  PC and IF/ID write enable; equal to ~depen.
- exe_load  out  1  EXE holds a valid register-writing load.
- stall_cnt  out  CNT_W  number of stall cycles since reset, saturating.

Behaviour:
- State: EXE slot {e_wreg, e_m2reg, e_rd} and MEM slot {m_wreg, m_m2reg, m_rd}. A bubble is wreg=0, m2reg=0, rd=0.
- Reset (synchronous, while reset=1 at a rising edge): both slots become bubbles, stall_cnt=0.
  - Output values after reset: fwda=fwdb=00, depen=0, wpcir=1, exe_load=0.
- Each rising edge with reset=0:
  - MEM slot is loaded from the EXE slot.
  - EXE slot is loaded from ID when id_valid=1, id_flush=0 and depen=0. Otherwise the EXE slot is loaded with a bubble.
- Producer qualification: register 0 is never a producer. A stage whose rd=0 or wreg=0 matches nothing.
- exe_load = e_wreg & e_m2reg & (e_rd != 0). This is combinational from state.
- Hazard match for rs:
  - ehit_rs = id_valid & id_use_rs & e_wreg & (e_rd != 0) & (e_rd == id_rs).
  - mhit_rs is the same test against the MEM slot.
  - ehit_rt and mhit_rt are the same tests using id_rt and id_use_rt.
- Forwarding select for A (combinational, same cycle as the ID inputs). EXE has priority over MEM (newest producer wins):
  - ehit_rs & ~e_m2reg gives 01.
  - Otherwise, mhit_rs & ~m_m2reg gives 10.
  - Otherwise, mhit_rs & m_m2reg gives 11.
  - Otherwise 00.
  - fwdb uses the same rules with rt.
- Load-use stall: depen = exe_load & (ehit_rs | ehit_rt).
  - depen does not depend on id_flush. A flushed instruction's stall is harmless because the bubble is injected anyway.
  - While depen=1, fwda/fwdb for the EXE-hit operand are don't-care.
  - One cycle later the load is in MEM, so depen falls and the select becomes 11.
- A stall lasts exactly one cycle per load-use pair. Back-to-back dependent instructions never produce two consecutive stalls from the same load.
- The write-back stage is not tracked. The register file writes on the falling edge, so WB-to-ID forwarding is not required.
- stall_cnt increments on every rising edge with reset=0 and depen=1. It holds at all-ones.
- Simultaneous events:
  - id_flush together with depen: a bubble is inserted, stall_cnt still increments and wpcir=0.
  - Reset mid-stall: the slots clear, so depen=0 on the next cycle.

Test Plan:
- Reset with arbitrary inputs: hold reset=1 for 2 cycles, then release with all id_* inputs at 0. Required: fwda=fwdb=00, depen=0, wpcir=1, exe_load=0, stall_cnt=0.
- ALU chain:
  - Issue add r3 (wreg=1, rd=3).
  - Next cycle issue an instruction with rs=3, rt=3. Required: fwda=fwdb=01, depen=0.
  - Next cycle issue rs=3 with no new writer. Required: fwda=10.
- Load-use:
  - Issue lw r5 (wreg=1, m2reg=1, rd=5).
  - Next cycle ID has rt=5, use_rt=1. Required: exe_load=1, depen=1, wpcir=0.
  - Next cycle, same ID inputs: depen=0, fwdb=11, stall_cnt=1.
- Priority: r7 written in MEM (ALU) and in EXE (ALU), ID rs=7. Required: fwda=01, not 10.
- r0 immunity: issue a writer with rd=0, then ID rs=0. Required: fwda=00, depen=0. Also a load to r0 followed by a use of r0 gives depen=0.
- Flush and saturation:
  - id_flush=1 on a writer to r9, then ID rs=9. Required: fwda=00.
  - Force 2^CNT_W+3 stalls (CNT_W=4 build). Required: stall_cnt=15 stays at 15.
